nmos_gate_driver: RTL and testbench

Dead-time-controlled gate driver for a half-bridge built from two `mosfet_channel_n` switches. It sits directly upstream of the NMOS stage: `gate_hi` drives the high-side transistor's `gate` and `gate_lo` drives the low-side transistor's `gate`. It generates a fixed-period PWM with programmable duty and dead time, and guarantees the two gates are never high in the same cycle. Configuration is sampled once per PWM cycle so that mid-cycle changes cannot produce shoot-through.

---
 rtl/nmos_gate_driver.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_nmos_gate_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nmos_gate_driver.sv
`default_nettype none
// ============================================================================
// Module      : nmos_gate_driver
// Description : Dead-time controlled half-bridge PWM gate driver; config is
//               latched once per PWM cycle. Optional FAULT input/state is
//               enabled by defining NMOS_GATE_DRV_FAULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nmos_gate_driver #(
    parameter int CNT_W  = 8,
    parameter int DEAD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  duty,
    input  logic [DEAD_W-1:0] dead,
`ifdef NMOS_GATE_DRV_FAULT_EN
    input  logic              fault,
    output logic              fault_latched,
`endif
    output logic              gate_hi,
    output logic              gate_lo,
    output logic              cycle_done,
    output logic              cfg_err
);

    localparam int c_aw = CNT_W + 1;
    localparam logic [CNT_W:0] c_one = {{CNT_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HI_ON   = 3'd1,
        S_DEAD_HL = 3'd2,
        S_LO_ON   = 3'd3,
        S_DEAD_LH = 3'd4,
        S_STOP    = 3'd5
`ifdef NMOS_GATE_DRV_FAULT_EN
        , S_FAULT = 3'd6
`endif
    } state_t;

    // configuration arithmetic on the live inputs, one bit wider than the counters
    logic [c_aw-1:0] w_p;
    logic [c_aw-1:0] w_d;
    logic [c_aw-1:0] w_t;
    logic [c_aw-1:0] w_t2;
    logic [c_aw-1:0] w_room;
    logic [c_aw-1:0] w_deff;
    logic [c_aw-1:0] w_l;
    logic            w_valid;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_aw-1:0] r_cnt;
    logic [c_aw-1:0] w_cnt_nxt;
    logic [c_aw-1:0] r_l;
    logic [c_aw-1:0] r_t;
    logic            r_abort;
    logic            w_abort_nxt;
    logic            r_cfg_err;
    logic            w_cfg_err_nxt;
    logic            w_latch;
    logic            w_last;

    state_t          w_start_state;
    logic [c_aw-1:0] w_start_cnt;
    state_t          w_end_state;
    logic [c_aw-1:0] w_end_cnt;
    logic            w_end_latch;
    logic            w_end_err;
    state_t          w_stop_state;
    logic [c_aw-1:0] w_stop_cnt;

    assign w_p     = {1'b0, period};
    assign w_d     = {1'b0, duty};
    assign w_t     = {{(c_aw-DEAD_W){1'b0}}, dead};
    assign w_t2    = {w_t[c_aw-2:0], 1'b0};
    assign w_valid = (w_p > w_t2);
    assign w_room  = w_p - w_t2;
    assign w_deff  = (w_d < w_room) ? w_d : w_room;
    assign w_l     = w_room - w_deff;

    assign w_last  = (r_cnt == c_one);

    // first non-empty state of a new cycle; a valid config guarantees D_eff+L >= 1
    always_comb begin
        w_start_state = S_LO_ON;
        w_start_cnt   = w_l;
        if (w_deff != '0) begin
            w_start_state = S_HI_ON;
            w_start_cnt   = w_deff;
        end else if (w_t != '0) begin
            w_start_state = S_DEAD_HL;
            w_start_cnt   = w_t;
        end
    end

    // decision taken at a cycle boundary (from IDLE or at the end of a cycle)
    always_comb begin
        w_end_state = S_IDLE;
        w_end_cnt   = '0;
        w_end_latch = 1'b0;
        w_end_err   = r_cfg_err;
        if (enable) begin
            if (w_valid) begin
                w_end_state = w_start_state;
                w_end_cnt   = w_start_cnt;
                w_end_latch = 1'b1;
                w_end_err   = 1'b0;
            end else begin
                w_end_err   = 1'b1;
            end
        end
    end

    always_comb begin
        w_stop_state = S_IDLE;
        w_stop_cnt   = '0;
        if (r_t != '0) begin
            w_stop_state = S_STOP;
            w_stop_cnt   = r_t;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt - c_one;
        w_abort_nxt   = r_abort;
        w_cfg_err_nxt = r_cfg_err;
        w_latch       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = '0;
                w_abort_nxt = 1'b0;
                if (enable) begin
                    w_state_nxt   = w_end_state;
                    w_cnt_nxt     = w_end_cnt;
                    w_latch       = w_end_latch;
                    w_cfg_err_nxt = w_end_err;
                end
            end

            S_HI_ON: begin
                if (!enable) begin
                    w_state_nxt = w_stop_state;
                    w_cnt_nxt   = w_stop_cnt;
                end else if (w_last) begin
                    if (r_t != '0) begin
                        w_state_nxt = S_DEAD_HL;
                        w_cnt_nxt   = r_t;
                    end else if (r_l != '0) begin
                        w_state_nxt = S_LO_ON;
                        w_cnt_nxt   = r_l;
                    end else begin
                        w_state_nxt   = w_end_state;
                        w_cnt_nxt     = w_end_cnt;
                        w_latch       = w_end_latch;
                        w_cfg_err_nxt = w_end_err;
                    end
                end
            end

            S_DEAD_HL: begin
                w_abort_nxt = r_abort | ~enable;
                if (w_last) begin
                    if (w_abort_nxt) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_l != '0) begin
                        w_state_nxt = S_LO_ON;
                        w_cnt_nxt   = r_l;
                    end else begin
                        w_state_nxt = S_DEAD_LH;
                        w_cnt_nxt   = r_t;
                    end
                end
            end

            S_LO_ON: begin
                if (!enable) begin
                    w_state_nxt = w_stop_state;
                    w_cnt_nxt   = w_stop_cnt;
                end else if (w_last) begin
                    if (r_t != '0) begin
                        w_state_nxt = S_DEAD_LH;
                        w_cnt_nxt   = r_t;
                    end else begin
                        w_state_nxt   = w_end_state;
                        w_cnt_nxt     = w_end_cnt;
                        w_latch       = w_end_latch;
                        w_cfg_err_nxt = w_end_err;
                    end
                end
            end

            S_DEAD_LH: begin
                w_abort_nxt = r_abort | ~enable;
                if (w_last) begin
                    if (w_abort_nxt) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt   = w_end_state;
                        w_cnt_nxt     = w_end_cnt;
                        w_latch       = w_end_latch;
                        w_cfg_err_nxt = w_end_err;
                    end
                end
            end

            S_STOP: begin
                // a re-asserted enable waits until the stop sequence has drained
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end

`ifdef NMOS_GATE_DRV_FAULT_EN
            S_FAULT: begin
                w_cnt_nxt   = '0;
                w_abort_nxt = 1'b0;
                if (!fault && !enable) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_abort_nxt = 1'b0;
            end
        endcase

`ifdef NMOS_GATE_DRV_FAULT_EN
        if (fault) begin
            w_state_nxt = S_FAULT;
            w_cnt_nxt   = '0;
            w_abort_nxt = 1'b0;
            w_latch     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_l       <= '0;
            r_t       <= '0;
            r_abort   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_abort   <= w_abort_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            if (w_latch) begin
                r_l <= w_l;
                r_t <= w_t;
            end
        end
    end

    assign gate_hi    = (r_state == S_HI_ON);
    assign gate_lo    = (r_state == S_LO_ON);
    assign cfg_err    = r_cfg_err;
    assign cycle_done = w_last && !r_abort &&
                        ((r_state == S_DEAD_LH) ||
                         ((r_state == S_LO_ON) && (r_t == '0)) ||
                         ((r_state == S_HI_ON) && (r_t == '0) && (r_l == '0)));
`ifdef NMOS_GATE_DRV_FAULT_EN
    assign fault_latched = (r_state == S_FAULT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_nmos_gate_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_nmos_gate_driver
// Description : Scoreboard bench for nmos_gate_driver with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nmos_gate_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] period;
    logic [7:0] duty;
    logic [3:0] dead;
    logic       gate_hi;
    logic       gate_lo;
    logic       cycle_done;
    logic       cfg_err;
`ifdef NMOS_GATE_DRV_FAULT_EN
    logic       fault;
    logic       fault_latched;
`endif

    typedef struct {
        logic  hi;
        logic  lo;
        logic  done;
        logic  err;
        logic  fl;
        string name;
    } exp_t;

    exp_t sq[$];
    exp_t aq[$];
    event ev_async;
    int   n_cmp = 0;
    int   n_bad = 0;

    nmos_gate_driver #(.CNT_W(8), .DEAD_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .period        (period),
        .duty          (duty),
        .dead          (dead),
`ifdef NMOS_GATE_DRV_FAULT_EN
        .fault         (fault),
        .fault_latched (fault_latched),
`endif
        .gate_hi       (gate_hi),
        .gate_lo       (gate_lo),
        .cycle_done    (cycle_done),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic hi, lo, done, err, fl, input string nm);
        exp_t e;
        e.hi = hi; e.lo = lo; e.done = done; e.err = err; e.fl = fl; e.name = nm;
        return e;
    endfunction

    task automatic check(input exp_t e);
        logic fl_act;
`ifdef NMOS_GATE_DRV_FAULT_EN
        fl_act = fault_latched;
`else
        fl_act = 1'b0;
`endif
        n_cmp++;
        if ({gate_hi, gate_lo, cycle_done, cfg_err, fl_act} !== {e.hi, e.lo, e.done, e.err, e.fl}) begin
            n_bad++;
            $display("FAIL %s: got hi/lo/done/err/fl=%b%b%b%b%b expected %b%b%b%b%b at %0t",
                     e.name, gate_hi, gate_lo, cycle_done, cfg_err, fl_act,
                     e.hi, e.lo, e.done, e.err, e.fl, $time);
        end
        n_cmp++;
        if (gate_hi && gate_lo) begin
            n_bad++;
            $display("FAIL overlap %s: got hi=1 lo=1 expected never both at %0t", e.name, $time);
        end
    endtask

    // clocked monitor: one expectation per clock, sampled 1 unit after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) check(sq.pop_front());
        end
    end

    // asynchronous monitor for checks between clock edges
    initial begin
        forever begin
            @(ev_async);
            if (aq.size() > 0) check(aq.pop_front());
        end
    end

    task automatic tick(input logic hi, lo, done, err, fl, input string nm);
        sq.push_back(mk(hi, lo, done, err, fl, nm));
        @(negedge clk);
    endtask

    task automatic seg(input int n, input logic hi, lo, done_last, err, input string nm);
        for (int i = 0; i < n; i++)
            tick(hi, lo, done_last && (i == n - 1), err, 1'b0, nm);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        period = 8'd2;
        duty   = 8'd0;
        dead   = 4'd1;
`ifdef NMOS_GATE_DRV_FAULT_EN
        fault  = 1'b0;
`endif
        @(negedge clk);
        seg(2, 0, 0, 0, 0, "reset_state");
        period = 8'd10; duty = 8'd3; dead = 4'd1; enable = 1'b0;
        reset  = 1'b0;
        seg(2, 0, 0, 0, 0, "idle_disabled");

        // P=10 D=3 T=1: hi 3, off 1, lo 5, off 1
        enable = 1'b1;
        repeat (2) begin
            seg(3, 1, 0, 0, 0, "t1_hi");
            seg(1, 0, 0, 0, 0, "t1_dead_hl");
            seg(5, 0, 1, 0, 0, "t1_lo");
            seg(1, 0, 0, 1, 0, "t1_dead_lh");
        end

        // D=0: high side skipped; then D=12 clamps to 8 and low side skipped
        duty = 8'd0;
        seg(1, 0, 0, 0, 0, "t2_d0_dead_hl");
        seg(8, 0, 1, 0, 0, "t2_d0_lo");
        seg(1, 0, 0, 1, 0, "t2_d0_dead_lh");
        duty = 8'd12;
        seg(8, 1, 0, 0, 0, "t2_clamp_hi");
        seg(2, 0, 0, 1, 0, "t2_clamp_dead");

        // P=2 T=1 invalid, then P=3 recovers with D_eff=0
        period = 8'd2; duty = 8'd0;
        seg(3, 0, 0, 0, 1, "t3_cfg_err");
        period = 8'd3;
        repeat (2) begin
            seg(1, 0, 0, 0, 0, "t3_dead_hl");
            seg(1, 0, 1, 0, 0, "t3_lo");
            seg(1, 0, 0, 1, 0, "t3_dead_lh");
        end

        // P=10 D=3 T=2 with mid-cycle duty change, then enable drop in HI_ON
        period = 8'd10; duty = 8'd3; dead = 4'd2;
        seg(1, 1, 0, 0, 0, "t4_hi");
        duty = 8'd6;
        seg(2, 1, 0, 0, 0, "t4_hi_old_duty");
        seg(2, 0, 0, 0, 0, "t4_dead_hl");
        seg(3, 0, 1, 0, 0, "t4_lo");
        seg(2, 0, 0, 1, 0, "t4_dead_lh");
        seg(6, 1, 0, 0, 0, "t4_hi_new_duty");
        seg(4, 0, 0, 1, 0, "t4_dead_both");
        seg(2, 1, 0, 0, 0, "t4_hi_before_stop");
        enable = 1'b0;
        seg(2, 0, 0, 0, 0, "t4_stop");
        seg(3, 0, 0, 0, 0, "t4_idle");

        // asynchronous reset in the middle of LO_ON
        period = 8'd10; duty = 8'd3; dead = 4'd1; enable = 1'b1;
        seg(3, 1, 0, 0, 0, "t5_hi");
        seg(1, 0, 0, 0, 0, "t5_dead_hl");
        seg(2, 0, 1, 0, 0, "t5_lo");
        aq.push_back(mk(0, 1, 0, 0, 0, "t5_lo_before_reset"));
        -> ev_async;
        #2;
        reset = 1'b1;
        #1;
        aq.push_back(mk(0, 0, 0, 0, 0, "t5_async_reset"));
        -> ev_async;
        @(negedge clk);
        seg(2, 0, 0, 0, 0, "t5_reset_hold");
        reset = 1'b0;
        seg(3, 1, 0, 0, 0, "t5_restart_hi");
        enable = 1'b0;
        seg(1, 0, 0, 0, 0, "t5_stop");
        seg(1, 0, 0, 0, 0, "t5_idle");

`ifdef NMOS_GATE_DRV_FAULT_EN
        enable = 1'b1;
        tick(1, 0, 0, 0, 0, "f_hi");
        fault = 1'b1;
        tick(0, 0, 0, 0, 1, "f_trip");
        fault = 1'b0;
        tick(0, 0, 0, 0, 1, "f_hold_enabled");
        tick(0, 0, 0, 0, 1, "f_hold_enabled");
        enable = 1'b0;
        tick(0, 0, 0, 0, 0, "f_clear");
`endif

        for (int i = 0; i < 5 && sq.size() > 0; i++) @(negedge clk);
        if (sq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations expected 0", sq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
